// File: rtl/mpsoc_ram_pkg.sv
// Shared constants and lane helpers for the 1R1W pipelined RAM.
// Byte lanes are 8 bits wide except the last one, which takes the remaining bits.
package mpsoc_ram_pkg;

    localparam int RLAT_MAX = 4;

    function automatic int lanes(input int dbits);
        return (dbits + 7) / 8;
    endfunction

    // The top lane of an odd-width word is clipped to the data width.
    function automatic int lane_msb(input int i, input int dbits);
        return (8 * i + 7 < dbits) ? 8 * i + 7 : dbits - 1;
    endfunction

endpackage

// File: rtl/mpsoc_ram_rdpipe.sv
// Data + valid delay line behind the RAM read port; DEPTH=0 is a plain wire.
// Each stage loads data only when its valid is set, so the output holds the last result.
module mpsoc_ram_rdpipe #(
    parameter int DBITS = 32,
    parameter int DEPTH = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [DBITS-1:0] src_data,
    input  logic             src_valid,
    output logic [DBITS-1:0] dst_data,
    output logic             dst_valid
);

    if (DEPTH == 0) begin : g_wire
        logic unused_clk_rst;
        assign unused_clk_rst = clk ^ rst_n;
        assign dst_data  = src_data;
        assign dst_valid = src_valid;
    end else begin : g_pipe
        logic [DBITS-1:0] data_q  [DEPTH];
        logic             valid_q [DEPTH];

        for (genvar s = 0; s < DEPTH; s++) begin : g_stage
            logic [DBITS-1:0] stage_data;
            logic             stage_valid;

            if (s == 0) begin : g_head
                assign stage_data  = src_data;
                assign stage_valid = src_valid;
            end else begin : g_tail
                assign stage_data  = data_q[s-1];
                assign stage_valid = valid_q[s-1];
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    data_q[s]  <= '0;
                    valid_q[s] <= 1'b0;
                end else begin
                    valid_q[s] <= stage_valid;
                    if (stage_valid) data_q[s] <= stage_data;
                end
            end
        end

        assign dst_data  = data_q[DEPTH-1];
        assign dst_valid = valid_q[DEPTH-1];
    end

endmodule

// File: rtl/mpsoc_ram_1r1w_pipelined.sv
// Simple-dual-port RAM with byte write enables, pipelined read and selectable
// read-during-write policy (old data, or new data on the enabled lanes).
module mpsoc_ram_1r1w_pipelined
    import mpsoc_ram_pkg::*;
#(
    parameter int ABITS  = 10,
    parameter int DBITS  = 32,
    parameter int RLAT   = 1,
    parameter int BYPASS = 1
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic [ABITS-1:0]         waddr_i,
    input  logic [DBITS-1:0]         din_i,
    input  logic                     we_i,
    input  logic [lanes(DBITS)-1:0]  be_i,
    input  logic [ABITS-1:0]         raddr_i,
    input  logic                     re_i,
    output logic [DBITS-1:0]         dout_o,
    output logic                     dvalid_o
);

    localparam int LANES = lanes(DBITS);
    localparam int DEPTH = 1 << ABITS;

    if (RLAT < 1 || RLAT > RLAT_MAX) begin : g_bad_rlat
        $error("mpsoc_ram_1r1w_pipelined: RLAT=%0d outside 1..%0d", RLAT, RLAT_MAX);
    end

    logic [DBITS-1:0] mem [DEPTH];
    logic [DBITS-1:0] wmask;
    logic [DBITS-1:0] rd_word;
    logic [DBITS-1:0] s1_data;
    logic             s1_valid;

    // The array is never reset so contents survive rst_ni.
    for (genvar g = 0; g < LANES; g++) begin : g_lane
        localparam int LO = 8 * g;
        localparam int HI = lane_msb(g, DBITS);

        assign wmask[HI:LO] = {(HI - LO + 1){be_i[g]}};

        always_ff @(posedge clk_i) begin
            if (we_i && be_i[g]) mem[waddr_i][HI:LO] <= din_i[HI:LO];
        end
    end

    // Same-edge collision: forward the enabled lanes of the incoming write.
    always_comb begin
        rd_word = mem[raddr_i];
        if (BYPASS != 0 && we_i && raddr_i == waddr_i) begin
            rd_word = (rd_word & ~wmask) | (din_i & wmask);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_data  <= '0;
            s1_valid <= 1'b0;
        end else begin
            s1_valid <= re_i;
            if (re_i) s1_data <= rd_word;
        end
    end

    mpsoc_ram_rdpipe #(
        .DBITS (DBITS),
        .DEPTH (RLAT - 1)
    ) u_rdpipe (
        .clk       (clk_i),
        .rst_n     (rst_ni),
        .src_data  (s1_data),
        .src_valid (s1_valid),
        .dst_data  (dout_o),
        .dst_valid (dvalid_o)
    );

endmodule

// File: tb/tb_mpsoc_ram_1r1w_pipelined.sv
// Directed bench: five RAM configurations share one stimulus stream, each checked
// against hand-computed values at its own read latency.
module tb_mpsoc_ram_1r1w_pipelined;

    logic        clk;
    logic        rst_n;
    logic        we;
    logic        re;
    logic [3:0]  be;
    logic [9:0]  waddr;
    logic [9:0]  raddr;
    logic [31:0] din;

    logic [31:0] dout0, dout1, dout3, dout4;
    logic [19:0] dout20;
    logic        v0, v1, v3, v4, v20;

    int checks = 0;
    int errors = 0;

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    mpsoc_ram_1r1w_pipelined #(.ABITS(10), .DBITS(32), .RLAT(1), .BYPASS(0)) u_old (
        .clk_i(clk), .rst_ni(rst_n), .waddr_i(waddr), .din_i(din), .we_i(we), .be_i(be),
        .raddr_i(raddr), .re_i(re), .dout_o(dout0), .dvalid_o(v0));

    mpsoc_ram_1r1w_pipelined #(.ABITS(10), .DBITS(32), .RLAT(1), .BYPASS(1)) u_new (
        .clk_i(clk), .rst_ni(rst_n), .waddr_i(waddr), .din_i(din), .we_i(we), .be_i(be),
        .raddr_i(raddr), .re_i(re), .dout_o(dout1), .dvalid_o(v1));

    mpsoc_ram_1r1w_pipelined #(.ABITS(10), .DBITS(32), .RLAT(3), .BYPASS(1)) u_lat3 (
        .clk_i(clk), .rst_ni(rst_n), .waddr_i(waddr), .din_i(din), .we_i(we), .be_i(be),
        .raddr_i(raddr), .re_i(re), .dout_o(dout3), .dvalid_o(v3));

    mpsoc_ram_1r1w_pipelined #(.ABITS(10), .DBITS(32), .RLAT(4), .BYPASS(0)) u_lat4 (
        .clk_i(clk), .rst_ni(rst_n), .waddr_i(waddr), .din_i(din), .we_i(we), .be_i(be),
        .raddr_i(raddr), .re_i(re), .dout_o(dout4), .dvalid_o(v4));

    mpsoc_ram_1r1w_pipelined #(.ABITS(10), .DBITS(20), .RLAT(2), .BYPASS(1)) u_w20 (
        .clk_i(clk), .rst_ni(rst_n), .waddr_i(waddr), .din_i(din[19:0]), .we_i(we),
        .be_i(be[2:0]), .raddr_i(raddr), .re_i(re), .dout_o(dout20), .dvalid_o(v20));

    typedef struct {
        logic        we;
        logic [3:0]  be;
        logic [9:0]  waddr;
        logic [31:0] din;
        logic        re;
        logic [9:0]  raddr;
        logic        exp_v;
        logic [31:0] exp_old;
        logic [31:0] exp_new;
    } vec_t;

    vec_t vecs[13];

    // scoreboard
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // driver tasks
    task automatic drive(input logic w, input logic [3:0] b, input logic [9:0] wa,
                         input logic [31:0] d, input logic r, input logic [9:0] ra);
        we = w; be = b; waddr = wa; din = d; re = r; raddr = ra;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] exp_d;

        vecs[0]  = '{1'b1, 4'hF, 10'h005, 32'hDEADBEEF, 1'b0, 10'h000, 1'b0, 32'h00000000, 32'h00000000};
        vecs[1]  = '{1'b0, 4'h0, 10'h000, 32'h00000000, 1'b1, 10'h005, 1'b1, 32'hDEADBEEF, 32'hDEADBEEF};
        vecs[2]  = '{1'b0, 4'h0, 10'h000, 32'h00000000, 1'b0, 10'h000, 1'b0, 32'hDEADBEEF, 32'hDEADBEEF};
        vecs[3]  = '{1'b1, 4'hF, 10'h010, 32'h11223344, 1'b0, 10'h000, 1'b0, 32'hDEADBEEF, 32'hDEADBEEF};
        vecs[4]  = '{1'b1, 4'h5, 10'h010, 32'hAABBCCDD, 1'b0, 10'h000, 1'b0, 32'hDEADBEEF, 32'hDEADBEEF};
        vecs[5]  = '{1'b0, 4'h0, 10'h000, 32'h00000000, 1'b1, 10'h010, 1'b1, 32'h11BB33DD, 32'h11BB33DD};
        vecs[6]  = '{1'b1, 4'h0, 10'h010, 32'hFFFFFFFF, 1'b0, 10'h000, 1'b0, 32'h11BB33DD, 32'h11BB33DD};
        vecs[7]  = '{1'b0, 4'h0, 10'h000, 32'h00000000, 1'b1, 10'h010, 1'b1, 32'h11BB33DD, 32'h11BB33DD};
        vecs[8]  = '{1'b1, 4'hF, 10'h020, 32'h00000000, 1'b0, 10'h000, 1'b0, 32'h11BB33DD, 32'h11BB33DD};
        vecs[9]  = '{1'b1, 4'h3, 10'h020, 32'hCAFEF00D, 1'b1, 10'h020, 1'b1, 32'h00000000, 32'h0000F00D};
        vecs[10] = '{1'b0, 4'h0, 10'h000, 32'h00000000, 1'b1, 10'h020, 1'b1, 32'h0000F00D, 32'h0000F00D};
        vecs[11] = '{1'b1, 4'hF, 10'h030, 32'h12345678, 1'b1, 10'h005, 1'b1, 32'hDEADBEEF, 32'hDEADBEEF};
        vecs[12] = '{1'b0, 4'h0, 10'h000, 32'h00000000, 1'b1, 10'h030, 1'b1, 32'h12345678, 32'h12345678};

        rst_n = 1'b0;
        drive(1'b0, 4'h0, 10'h000, 32'h0, 1'b0, 10'h000);
        #23;
        check("reset v_old", {31'b0, v0}, 32'h0);
        check("reset dout_old", dout0, 32'h0);
        check("reset v_lat3", {31'b0, v3}, 32'h0);
        check("reset dout_lat3", dout3, 32'h0);
        check("reset v_lat4", {31'b0, v4}, 32'h0);
        check("reset dout_w20", {12'b0, dout20}, 32'h0);
        rst_n = 1'b1;
        step();

        // table: RLAT=1 instances, result visible right after the issue edge
        for (int i = 0; i < 13; i++) begin
            drive(vecs[i].we, vecs[i].be, vecs[i].waddr, vecs[i].din, vecs[i].re, vecs[i].raddr);
            step();
            check($sformatf("vec%0d v_old", i), {31'b0, v0}, {31'b0, vecs[i].exp_v});
            check($sformatf("vec%0d v_new", i), {31'b0, v1}, {31'b0, vecs[i].exp_v});
            check($sformatf("vec%0d dout_old", i), dout0, vecs[i].exp_old);
            check($sformatf("vec%0d dout_new", i), dout1, vecs[i].exp_new);
        end

        // RLAT=3 throughput: preload a*0x01010101, then 8 back-to-back reads
        for (int a = 0; a < 8; a++) begin
            drive(1'b1, 4'hF, 10'(a), 32'(a) * 32'h01010101, 1'b0, 10'h000);
            step();
        end
        for (int k = 0; k < 12; k++) begin
            if (k < 8) drive(k == 3, 4'hF, 10'h002, 32'hFFFFFFFF, 1'b1, 10'(k));
            else       drive(1'b0, 4'h0, 10'h000, 32'h0, 1'b0, 10'h000);
            step();
            if (k < 2)       exp_d = 32'h12345678;
            else if (k <= 9) exp_d = 32'(k - 2) * 32'h01010101;
            else             exp_d = 32'h07070707;
            check($sformatf("lat3 k%0d valid", k), {31'b0, v3}, {31'b0, (k >= 2 && k <= 9)});
            check($sformatf("lat3 k%0d dout", k), dout3, exp_d);
        end

        // RLAT=4 reset with three reads in flight
        drive(1'b1, 4'hF, 10'h050, 32'h5A5A5A5A, 1'b0, 10'h000);
        step();
        drive(1'b0, 4'h0, 10'h000, 32'h0, 1'b1, 10'h050);
        step();
        drive(1'b0, 4'h0, 10'h000, 32'h0, 1'b1, 10'h005);
        step();
        drive(1'b0, 4'h0, 10'h000, 32'h0, 1'b1, 10'h010);
        step();
        check("lat4 pre-reset valid", {31'b0, v4}, 32'h0);
        check("lat4 pre-reset dout", dout4, 32'h07070707);
        drive(1'b0, 4'h0, 10'h000, 32'h0, 1'b0, 10'h000);
        #2 rst_n = 1'b0;
        #1;
        check("lat4 async reset valid", {31'b0, v4}, 32'h0);
        check("lat4 async reset dout", dout4, 32'h0);
        check("old async reset dout", dout0, 32'h0);
        #3 rst_n = 1'b1;
        for (int j = 0; j < 6; j++) begin
            step();
            check($sformatf("lat4 post-reset valid%0d", j), {31'b0, v4}, 32'h0);
        end
        drive(1'b0, 4'h0, 10'h000, 32'h0, 1'b1, 10'h050);
        for (int j = 0; j < 4; j++) begin
            step();
            drive(1'b0, 4'h0, 10'h000, 32'h0, 1'b0, 10'h000);
            if (j == 0) begin
                check("old preserved valid", {31'b0, v0}, 32'h1);
                check("old preserved dout", dout0, 32'h5A5A5A5A);
            end
            check($sformatf("lat4 reread valid%0d", j), {31'b0, v4}, {31'b0, j == 3});
        end
        check("lat4 preserved dout", dout4, 32'h5A5A5A5A);

        // DBITS=20, RLAT=2: 4-bit top lane and partial-lane forwarding
        drive(1'b1, 4'h7, 10'h000, 32'h00000000, 1'b0, 10'h000);
        step();
        drive(1'b1, 4'h4, 10'h000, 32'h000FFFFF, 1'b0, 10'h000);
        step();
        drive(1'b0, 4'h0, 10'h000, 32'h0, 1'b1, 10'h000);
        step();
        check("w20 first edge valid", {31'b0, v20}, 32'h0);
        drive(1'b0, 4'h0, 10'h000, 32'h0, 1'b0, 10'h000);
        step();
        check("w20 top lane valid", {31'b0, v20}, 32'h1);
        check("w20 top lane dout", {12'b0, dout20}, 32'h000F0000);
        drive(1'b1, 4'h1, 10'h000, 32'h00012345, 1'b1, 10'h000);
        step();
        drive(1'b0, 4'h0, 10'h000, 32'h0, 1'b0, 10'h000);
        step();
        check("w20 collision valid", {31'b0, v20}, 32'h1);
        check("w20 collision dout", {12'b0, dout20}, 32'h000F0045);
        step();
        check("w20 idle valid", {31'b0, v20}, 32'h0);
        check("w20 idle hold", {12'b0, dout20}, 32'h000F0045);

        // final report
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
